// File: rtl/alu_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter_if
// Bundles the signals between the ALU issue arbiter and its surroundings:
// the four reservation stations, the shared ALU and the common data bus.
//
// Signal summary (direction as seen by the arbiter, i.e. the master modport):
//   rs_req     in   [3:0]        per-station issue request, bit i = station i
//   rs_tag     in   [3:0][2:0]   ROB tag of each station's ready instruction
//   rs_a/rs_b  in   [3:0][31:0]  per-station resolved operands
//   rs_funct3  in   [3:0][2:0]   per-station ALU funct3
//   rs_funct7  in   [3:0]        per-station ALU funct7 select bit
//   rs_grant   out  [3:0]        one-hot grant pulse to the winning station
//   alu_start  out               one-cycle ALU launch pulse
//   alu_a/b    out  [31:0]       latched ALU operands
//   alu_funct3 out  [2:0]        latched ALU funct3
//   alu_funct7 out               latched ALU funct7 bit
//   alu_done   in                ALU result valid (one-cycle pulse)
//   alu_result in   [31:0]       ALU result, valid with alu_done
//   cdb_req    out               request to broadcast on the CDB
//   cdb_ack    in                CDB accepted the broadcast this cycle
//   cdb_tag    out  [2:0]        broadcast ROB tag
//   cdb_data   out  [31:0]       broadcast result
//   busy       out               arbiter is not idle
// -----------------------------------------------------------------------------
interface alu_issue_arbiter_if;
  logic [3:0]        rs_req;
  logic [3:0][2:0]   rs_tag;
  logic [3:0][31:0]  rs_a;
  logic [3:0][31:0]  rs_b;
  logic [3:0][2:0]   rs_funct3;
  logic [3:0]        rs_funct7;
  logic [3:0]        rs_grant;

  logic              alu_start;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_funct3;
  logic              alu_funct7;
  logic              alu_done;
  logic [31:0]       alu_result;

  logic              cdb_req;
  logic              cdb_ack;
  logic [2:0]        cdb_tag;
  logic [31:0]       cdb_data;

  logic              busy;

  // Arbiter side.
  modport master (
    input  rs_req, rs_tag, rs_a, rs_b, rs_funct3, rs_funct7,
    output rs_grant,
    output alu_start, alu_a, alu_b, alu_funct3, alu_funct7,
    input  alu_done, alu_result,
    output cdb_req, cdb_tag, cdb_data,
    input  cdb_ack,
    output busy
  );

  // Environment side: stations, ALU and CDB.
  modport slave (
    output rs_req, rs_tag, rs_a, rs_b, rs_funct3, rs_funct7,
    input  rs_grant,
    input  alu_start, alu_a, alu_b, alu_funct3, alu_funct7,
    output alu_done, alu_result,
    input  cdb_req, cdb_tag, cdb_data,
    output cdb_ack,
    input  busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
// Arbitrates four reservation stations onto a single ALU with round-robin
// fairness, launches the chosen operation, waits for the ALU result and then
// broadcasts the result with its ROB tag on the common data bus.
//
// One operation is in flight at a time: IDLE -> EXEC -> BCAST -> IDLE, so the
// tightest issue-to-issue spacing is three cycles.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  alu_issue_arbiter_if.master (station, ALU and CDB signals)
// -----------------------------------------------------------------------------
module alu_issue_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    BCAST = 2'd2
  } state_t;

  // Control state.
  state_t       r_state;
  logic [1:0]   r_rr_ptr;   // station scanned first in the next arbitration
  logic [2:0]   r_tag;      // ROB tag of the operation in flight

  // Registered outputs.
  logic [3:0]   r_grant;
  logic         r_start;
  logic [31:0]  r_alu_a;
  logic [31:0]  r_alu_b;
  logic [2:0]   r_alu_funct3;
  logic         r_alu_funct7;
  logic         r_cdb_req;
  logic [2:0]   r_cdb_tag;
  logic [31:0]  r_cdb_data;

  // Arbitration result.
  logic         w_found;
  logic [1:0]   w_winner;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first requesting station starting at r_rr_ptr and
  // wrapping modulo 4. The 2-bit index wraps naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [1:0] idx;
    // NOTE: every variable gets a default before the loop so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    idx      = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr_ptr + 2'(k);
      if (!w_found && bus.rs_req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered outputs.
  // rs_grant / alu_start default low every cycle and are only raised on the
  // IDLE->EXEC edge, which makes them single-cycle pulses in the first EXEC
  // cycle. alu_* operands hold until the next grant; cdb_tag/cdb_data hold
  // until the next result is captured.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge, independent of statement
  // order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 2'd0;
      r_tag        <= 3'd0;
      r_grant      <= 4'd0;
      r_start      <= 1'b0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_funct3 <= 3'd0;
      r_alu_funct7 <= 1'b0;
      r_cdb_req    <= 1'b0;
      r_cdb_tag    <= 3'd0;
      r_cdb_data   <= 32'd0;
    end else begin
      r_grant <= 4'd0;
      r_start <= 1'b0;

      unique case (r_state)
        IDLE: begin
          // alu_done and cdb_ack are deliberately not looked at here.
          if (w_found) begin
            r_alu_a      <= bus.rs_a[w_winner];
            r_alu_b      <= bus.rs_b[w_winner];
            r_alu_funct3 <= bus.rs_funct3[w_winner];
            r_alu_funct7 <= bus.rs_funct7[w_winner];
            r_tag        <= bus.rs_tag[w_winner];
            r_grant      <= 4'b0001 << w_winner;
            r_start      <= 1'b1;
            r_rr_ptr     <= w_winner + 2'd1;
            r_state      <= EXEC;
          end
        end

        EXEC: begin
          // New requests wait; the ALU may finish as early as the launch cycle.
          if (bus.alu_done) begin
            r_cdb_data <= bus.alu_result;
            r_cdb_tag  <= r_tag;
            r_cdb_req  <= 1'b1;
            r_state    <= BCAST;
          end
        end

        BCAST: begin
          if (bus.cdb_ack) begin
            r_cdb_req <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_cdb_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive.
  // ---------------------------------------------------------------------------
  assign bus.rs_grant   = r_grant;
  assign bus.alu_start  = r_start;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_funct3 = r_alu_funct3;
  assign bus.alu_funct7 = r_alu_funct7;
  assign bus.cdb_req    = r_cdb_req;
  assign bus.cdb_tag    = r_cdb_tag;
  assign bus.cdb_data   = r_cdb_data;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
// Directed testbench for alu_issue_arbiter. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point, so each tick()
// advances exactly one cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_issue_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_issue_arbiter_if bus ();

  alu_issue_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_req     = 4'd0;
    bus.alu_done   = 1'b0;
    bus.alu_result = 32'd0;
    bus.cdb_ack    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rs_tag[i]    = 3'(i + 4);
      bus.rs_a[i]      = 32'h100 + 32'(i);
      bus.rs_b[i]      = 32'h200 + 32'(i);
      bus.rs_funct3[i] = 3'(i);
      bus.rs_funct7[i] = i[0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_tests++;
    if (bus.rs_grant !== 4'd0 || bus.alu_start !== 1'b0 || bus.busy !== 1'b0 ||
        bus.cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b start=%b busy=%b cdb_req=%b, expected all 0",
               bus.rs_grant, bus.alu_start, bus.busy, bus.cdb_req);
    end
    n_tests++;
    if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_funct3 !== 3'd0 ||
        bus.alu_funct7 !== 1'b0 || bus.cdb_tag !== 3'd0 || bus.cdb_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h f3=%h f7=%b tag=%h data=%h, expected all 0",
               bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7, bus.cdb_tag, bus.cdb_data);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    clear_inputs();
    do_reset();
    bus.rs_req       = 4'b0010;
    bus.rs_tag[1]    = 3'd1;
    bus.rs_a[1]      = 32'd5;
    bus.rs_b[1]      = 32'd3;
    bus.rs_funct3[1] = 3'b000;
    bus.rs_funct7[1] = 1'b0;
    tick();  // first EXEC cycle
    n_tests++;
    if (bus.rs_grant !== 4'b0010 || bus.alu_start !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b start=%b busy=%b, expected 0010 1 1",
               bus.rs_grant, bus.alu_start, bus.busy);
    end
    n_tests++;
    if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 || bus.alu_funct3 !== 3'd0) begin
      n_fail++;
      $display("FAIL single_operands: a=%0d b=%0d f3=%0d, expected 5 3 0",
               bus.alu_a, bus.alu_b, bus.alu_funct3);
    end
    bus.rs_req = 4'd0;
    tick();  // second EXEC cycle
    n_tests++;
    if (bus.rs_grant !== 4'd0 || bus.alu_start !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse_width: grant=%b start=%b busy=%b, expected 0000 0 1",
               bus.rs_grant, bus.alu_start, bus.busy);
    end
    tick();  // third EXEC cycle: ALU finishes
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'd8;
    n_tests++;
    if (bus.cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_early_cdb: cdb_req=%b, expected 0", bus.cdb_req);
    end
    tick();  // first BCAST cycle
    bus.alu_done = 1'b0;
    n_tests++;
    if (bus.cdb_req !== 1'b1 || bus.cdb_tag !== 3'd1 || bus.cdb_data !== 32'd8) begin
      n_fail++;
      $display("FAIL single_bcast: req=%b tag=%0d data=%0d, expected 1 1 8",
               bus.cdb_req, bus.cdb_tag, bus.cdb_data);
    end
    bus.cdb_ack = 1'b1;
    tick();  // back in IDLE
    bus.cdb_ack = 1'b0;
    n_tests++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0 || bus.alu_a !== 32'd5) begin
      n_fail++;
      $display("FAIL single_idle: req=%b busy=%b a=%0d, expected 0 0 5",
               bus.cdb_req, bus.busy, bus.alu_a);
    end
    tick();  // idle with no request: operands must hold
    n_tests++;
    if (bus.busy !== 1'b0 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin
      n_fail++;
      $display("FAIL single_hold: busy=%b a=%0d b=%0d, expected 0 5 3",
               bus.busy, bus.alu_a, bus.alu_b);
    end
  endtask

  // ---------------------------------------------------------------------------
  // All four stations request; ALU and CDB respond at once. Each station
  // drops its request once granted.
  task automatic test_back_to_back();
    int         n_grants;
    int         last_cyc;
    logic [3:0] exp_g;
    logic [2:0] exp_tag;
    clear_inputs();
    do_reset();
    bus.rs_req     = 4'b1111;
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'hCAFE;
    bus.cdb_ack    = 1'b1;
    n_grants = 0;
    last_cyc = 0;
    exp_tag  = 3'd0;
    for (int cyc = 0; cyc < 30 && n_grants < 4; cyc++) begin
      tick();
      if (bus.cdb_req === 1'b1) begin
        n_tests++;
        if (bus.cdb_tag !== exp_tag) begin
          n_fail++;
          $display("FAIL b2b_cdb_tag: got %0d expected %0d", bus.cdb_tag, exp_tag);
        end
      end
      if (bus.rs_grant !== 4'd0) begin
        exp_g = 4'(1 << n_grants);
        n_tests++;
        if (bus.rs_grant !== exp_g) begin
          n_fail++;
          $display("FAIL b2b_order: grant #%0d got %b expected %b", n_grants, bus.rs_grant, exp_g);
        end
        if (n_grants > 0) begin
          n_tests++;
          if (cyc - last_cyc != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: grant #%0d got %0d cycles expected 3",
                     n_grants, cyc - last_cyc);
          end
        end
        exp_tag     = 3'(n_grants + 4);
        last_cyc    = cyc;
        bus.rs_req  = bus.rs_req & ~bus.rs_grant;
        n_grants++;
      end
    end
    n_tests++;
    if (n_grants != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d grants expected 4", n_grants);
    end
    bus.rs_req = 4'd0;
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b cdb_req=%b expected 0 0", bus.busy, bus.cdb_req);
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Stations 0 and 2 request continuously: grants must alternate.
  task automatic test_fairness();
    logic [3:0] exp_f [4];
    int         n_grants;
    exp_f = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    clear_inputs();
    do_reset();
    bus.rs_req   = 4'b0101;
    bus.alu_done = 1'b1;
    bus.cdb_ack  = 1'b1;
    n_grants = 0;
    for (int cyc = 0; cyc < 40 && n_grants < 4; cyc++) begin
      tick();
      if (bus.rs_grant !== 4'd0) begin
        n_tests++;
        if (bus.rs_grant !== exp_f[n_grants]) begin
          n_fail++;
          $display("FAIL fair_order: grant #%0d got %b expected %b",
                   n_grants, bus.rs_grant, exp_f[n_grants]);
        end
        n_grants++;
      end
    end
    n_tests++;
    if (n_grants != 4) begin
      n_fail++;
      $display("FAIL fair_count: got %0d grants expected 4", n_grants);
    end
    clear_inputs();
    tick();
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // CDB holds off for 5 BCAST cycles; payload must stay put, no new grants.
  task automatic test_backpressure();
    int waited;
    clear_inputs();
    do_reset();
    bus.rs_req    = 4'b1111;
    bus.rs_tag[0] = 3'd5;
    waited = 0;
    tick();
    while (bus.rs_grant === 4'd0 && waited < 10) begin
      tick();
      waited++;
    end
    n_tests++;
    if (bus.rs_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_first_grant: got %b expected 0001", bus.rs_grant);
    end
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'hDEAD_BEEF;
    tick();  // first BCAST cycle
    bus.alu_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (bus.cdb_req !== 1'b1 || bus.cdb_tag !== 3'd5 || bus.cdb_data !== 32'hDEAD_BEEF ||
          bus.rs_grant !== 4'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: req=%b tag=%0d data=%h grant=%b, expected 1 5 deadbeef 0000",
                 i, bus.cdb_req, bus.cdb_tag, bus.cdb_data, bus.rs_grant);
      end
      if (i == 5) bus.cdb_ack = 1'b1;
      tick();
    end
    bus.cdb_ack = 1'b0;
    n_tests++;
    if (bus.cdb_req !== 1'b0 || bus.rs_grant !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: req=%b grant=%b busy=%b, expected 0 0000 0",
               bus.cdb_req, bus.rs_grant, bus.busy);
    end
    tick();  // IDLE edge grants the next station in round-robin order
    n_tests++;
    if (bus.rs_grant !== 4'b0010 || bus.alu_a !== 32'h101) begin
      n_fail++;
      $display("FAIL bp_next_grant: grant=%b a=%h, expected 0010 101", bus.rs_grant, bus.alu_a);
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Reset in the second EXEC cycle, then a late alu_done.
  task automatic test_reset_mid_exec();
    clear_inputs();
    do_reset();
    bus.rs_req  = 4'b0100;
    bus.rs_a[2] = 32'h1234;
    tick();  // first EXEC cycle, rr_ptr now 3
    n_tests++;
    if (bus.rs_grant !== 4'b0100 || bus.alu_a !== 32'h1234) begin
      n_fail++;
      $display("FAIL rst_mid_grant: grant=%b a=%h, expected 0100 1234", bus.rs_grant, bus.alu_a);
    end
    bus.rs_req = 4'b1010;
    tick();  // second EXEC cycle
    rst = 1'b1;
    tick();  // reset applied
    n_tests++;
    if (bus.rs_grant !== 4'd0 || bus.alu_start !== 1'b0 || bus.alu_a !== 32'd0 ||
        bus.alu_b !== 32'd0 || bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: grant=%b start=%b a=%h b=%h req=%b busy=%b, expected all 0",
               bus.rs_grant, bus.alu_start, bus.alu_a, bus.alu_b, bus.cdb_req, bus.busy);
    end
    rst            = 1'b0;
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'd99;
    tick();  // late alu_done ignored; lowest-index requester wins
    bus.alu_done = 1'b0;
    n_tests++;
    if (bus.rs_grant !== 4'b0010 || bus.cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_next_grant: grant=%b cdb_req=%b, expected 0010 0",
               bus.rs_grant, bus.cdb_req);
    end
    bus.rs_req = 4'd0;
    tick();
    n_tests++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_no_cdb: cdb_req=%b busy=%b, expected 0 1", bus.cdb_req, bus.busy);
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // alu_done / cdb_ack while idle and nothing requests.
  task automatic test_spurious();
    clear_inputs();
    do_reset();
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'h5555;
    bus.cdb_ack    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.cdb_req !== 1'b0 || bus.rs_grant !== 4'd0 ||
          bus.cdb_data !== 32'd0) begin
        n_fail++;
        $display("FAIL spurious[%0d]: busy=%b req=%b grant=%b data=%h, expected 0 0 0000 0",
                 i, bus.busy, bus.cdb_req, bus.rs_grant, bus.cdb_data);
      end
    end
    bus.alu_done = 1'b0;
    bus.cdb_ack  = 1'b0;
    bus.rs_req   = 4'b1001;
    tick();
    n_tests++;
    if (bus.rs_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL spurious_then_grant: got %b expected 0001", bus.rs_grant);
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_backpressure();
    test_reset_mid_exec();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
